// File: rtl/tmds_pll_supervisor.sv
// TMDS PLL supervisor: sequences the PLL reset, synchronises and qualifies
// the PLL lock, and releases an active-low reset to the pixel/serial logic.
// Lock loss, lock timeout or a forced request restart the whole sequence.
module tmds_pll_supervisor #(
  parameter int RESET_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock_i,
  input  logic       force_relock_i,
  output logic       pll_reset_o,
  output logic       locked_o,
  output logic       rst_out_n,
  output logic [7:0] relock_cnt_o,
  output logic       fault_o
);

  localparam int MAX_RS  = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_RST_PLL   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_reset_q, pll_reset_d;
  logic                   locked_q, locked_d;
  logic                   rst_out_n_q, rst_out_n_d;
  logic [7:0]             relock_cnt_q, relock_cnt_d;
  logic                   fault_q, fault_d;
  logic                   lock_s;
  logic                   relock_inc;
  logic                   timeout;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Lock synchroniser: shift the asynchronous PLL lock through the flop chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_i};
  end

  // Sequencer: next state, shared per-state counter and restart events
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    relock_inc = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == RESET_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (force_relock_i) begin
          state_d    = ST_RST_PLL;
          cnt_d      = '0;
          relock_inc = 1'b1;
        end else if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_RST_PLL;
          cnt_d      = '0;
          relock_inc = 1'b1;
          timeout    = 1'b1;
        end
      end
      ST_STABLE: begin
        if (force_relock_i) begin
          state_d    = ST_RST_PLL;
          cnt_d      = '0;
          relock_inc = 1'b1;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (force_relock_i || !lock_s) begin
          state_d    = ST_RST_PLL;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_RST_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is a clean flop
  always_comb begin
    pll_reset_d  = (state_d == ST_RST_PLL);
    locked_d     = (state_d == ST_RUN);
    rst_out_n_d  = (state_d == ST_RUN);
    fault_d      = timeout;
    relock_cnt_d = relock_cnt_q;
    if (relock_inc && (relock_cnt_q != 8'hFF)) begin
      relock_cnt_d = relock_cnt_q + 8'd1;
    end
  end

  // State and output registers, all cleared asynchronously by resetn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RST_PLL;
      cnt_q        <= '0;
      sync_q       <= '0;
      pll_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      rst_out_n_q  <= 1'b0;
      relock_cnt_q <= 8'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      pll_reset_q  <= pll_reset_d;
      locked_q     <= locked_d;
      rst_out_n_q  <= rst_out_n_d;
      relock_cnt_q <= relock_cnt_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_reset_o  = pll_reset_q;
  assign locked_o     = locked_q;
  assign rst_out_n    = rst_out_n_q;
  assign relock_cnt_o = relock_cnt_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Self-checking bench for tmds_pll_supervisor with small parameters
// (reset 4, stable 8, timeout 32, 2 sync stages). Each table record holds
// inputs for N cycles; outputs are checked on the falling edge after every
// rising edge.
module tb_tmds_pll_supervisor;

  logic       clk;
  logic       resetn;
  logic       pll_lock_i;
  logic       force_relock_i;
  logic       pll_reset_o;
  logic       locked_o;
  logic       rst_out_n;
  logic [7:0] relock_cnt_o;
  logic       fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit rst;
    bit lock;
    bit frc;
    int n;
    bit pll;
    bit lk;
    bit ro;
    int rc;
    bit flt;
  } vec_t;

  vec_t vecs[$];

  tmds_pll_supervisor #(
    .RESET_CYCLES  (4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(32),
    .SYNC_STAGES   (2)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_lock_i    (pll_lock_i),
    .force_relock_i(force_relock_i),
    .pll_reset_o   (pll_reset_o),
    .locked_o      (locked_o),
    .rst_out_n     (rst_out_n),
    .relock_cnt_o  (relock_cnt_o),
    .fault_o       (fault_o)
  );

  // Free-running 100 time-unit-period-agnostic clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the stimulus stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void add_vec(bit rst, bit lock, bit frc, int n,
                                  bit pll, bit lk, bit ro, int rc, bit flt);
    vec_t v;
    v.rst = rst; v.lock = lock; v.frc = frc; v.n = n;
    v.pll = pll; v.lk = lk; v.ro = ro; v.rc = rc; v.flt = flt;
    vecs.push_back(v);
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge
  task automatic applyStimulus(input bit rst, input bit lock, input bit frc);
    resetn         = !rst;
    pll_lock_i     = lock;
    force_relock_i = frc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkBit(input string tag, input logic act, input bit exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input bit pll, input bit lk,
                             input bit ro, input int rc, input bit flt);
    checkBit({tag, " pll_reset_o"}, pll_reset_o, pll);
    checkBit({tag, " locked_o"}, locked_o, lk);
    checkBit({tag, " rst_out_n"}, rst_out_n, ro);
    checkBit({tag, " fault_o"}, fault_o, flt);
    n_checks++;
    if (relock_cnt_o !== rc[7:0]) begin
      n_fail++;
      $display("[TB] FAIL %s relock_cnt_o: got %0d expected %0d", tag, relock_cnt_o, rc);
    end
  endtask

  initial begin
    int exp_rc;
    resetn         = 1'b0;
    pll_lock_i     = 1'b0;
    force_relock_i = 1'b0;

    // Phase A: clean lock-up, lock loss in RUN, force coincident with loss,
    // force during RST_PLL, glitch during qualification
    add_vec(1, 0, 0, 1,  1, 0, 0, 0, 0);   // reset values
    add_vec(0, 0, 0, 3,  1, 0, 0, 0, 0);   // reset pulse cycles 2..4
    add_vec(0, 0, 0, 7,  0, 0, 0, 0, 0);   // waiting, no lock yet
    add_vec(0, 1, 0, 10, 0, 0, 0, 0, 0);   // lock rises: 2 sync + 8 stable
    add_vec(0, 1, 0, 5,  0, 1, 1, 0, 0);   // released
    add_vec(0, 0, 0, 1,  0, 1, 1, 0, 0);   // one-cycle lock drop enters sync
    add_vec(0, 1, 0, 1,  0, 1, 1, 0, 0);   // lock_s now low, still RUN
    add_vec(0, 1, 0, 4,  1, 0, 0, 1, 0);   // relock: 4-cycle PLL reset
    add_vec(0, 1, 0, 9,  0, 0, 0, 1, 0);   // wait + stable window
    add_vec(0, 1, 0, 3,  0, 1, 1, 1, 0);   // re-released
    add_vec(0, 0, 0, 1,  0, 1, 1, 1, 0);   // drop lock again
    add_vec(0, 1, 0, 1,  0, 1, 1, 1, 0);   // lock_s falls now
    add_vec(0, 1, 1, 1,  1, 0, 0, 2, 0);   // force + loss together: +1 only
    add_vec(0, 1, 1, 1,  1, 0, 0, 2, 0);   // force in RST_PLL ignored
    add_vec(0, 1, 0, 2,  1, 0, 0, 2, 0);   // pulse completes at 4
    add_vec(0, 1, 0, 1,  0, 0, 0, 2, 0);   // WAIT_LOCK, pulse not extended
    add_vec(0, 1, 0, 4,  0, 0, 0, 2, 0);   // STABLE cnt 0..3
    add_vec(0, 0, 0, 1,  0, 0, 0, 2, 0);   // glitch reaches lock_s at cnt 5
    add_vec(0, 1, 0, 10, 0, 0, 0, 2, 0);   // fresh full 8-cycle window needed
    add_vec(0, 1, 0, 2,  0, 1, 1, 2, 0);   // released after full window
    // Phase B: lock never arrives, three timeouts every 36 cycles
    add_vec(1, 0, 0, 1,  1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 3,  1, 0, 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      add_vec(0, 0, 0, 32, 0, 0, 0, t,     0);
      add_vec(0, 0, 0, 1,  1, 0, 0, t + 1, 1);
      add_vec(0, 0, 0, 3,  1, 0, 0, t + 1, 0);
    end

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        applyStimulus(vecs[i].rst, vecs[i].lock, vecs[i].frc);
        checkOutput($sformatf("vec%0d.%0d", i, k), vecs[i].pll, vecs[i].lk,
                    vecs[i].ro, vecs[i].rc, vecs[i].flt);
      end
    end

    // Saturation: 300 forced relocks from WAIT_LOCK, lock held low
    applyStimulus(0, 0, 0);
    checkOutput("sat_enter_wait", 0, 0, 0, 3, 0);
    exp_rc = 3;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 1);
      exp_rc = (exp_rc == 255) ? 255 : exp_rc + 1;
      checkOutput($sformatf("sat_force%0d", i), 1, 0, 0, exp_rc, 0);
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0);
    end
    checkOutput("sat_final", 0, 0, 0, 255, 0);

    // Asynchronous reset in the middle of WAIT_LOCK, checked before any edge
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
